// File: rtl/down_counter_pkg.sv
// down_counter_pkg: shared defaults for the down counter (width, reset value, max count).
package down_counter_pkg;
   localparam int DEF_WIDTH = 4;
   localparam logic [DEF_WIDTH-1:0] MAX_COUNT = {DEF_WIDTH{1'b1}};
   localparam logic [DEF_WIDTH-1:0] DEF_RESET_VAL = MAX_COUNT;
endpackage

// File: rtl/down_counter_4bit.sv
// down_counter_4bit: free-running wrap-around down counter with zero flag and terminal-count pulse.
// Optional parallel load (load, load_val ports) enabled by defining DOWN_COUNTER_LOAD_EN.
module down_counter_4bit
   import down_counter_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             rst,
`ifdef DOWN_COUNTER_LOAD_EN
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
`endif
   output logic [WIDTH-1:0] count,
   output logic             zero,
   output logic             tc
);
   logic [WIDTH-1:0] count_nxt;
   logic             tc_nxt;
   // Decrementing from zero wraps to max, so the pulse is raised whenever we leave zero by decrement.
   always_comb begin
`ifdef DOWN_COUNTER_LOAD_EN
      count_nxt = load ? load_val : count - 1'b1;
      tc_nxt    = !load && (count == '0);
`else
      count_nxt = count - 1'b1;
      tc_nxt    = (count == '0);
`endif
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= RESET_VAL;
         tc    <= 1'b0;
      end else begin
         count <= count_nxt;
         tc    <= tc_nxt;
      end
   end
   assign zero = (count == '0);
endmodule

// File: tb/tb_down_counter_4bit.sv
// tb_down_counter_4bit: randomized self-checking bench against an arithmetic model of the counter.
module tb_down_counter_4bit;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] count;
   logic       zero;
   logic       tc;
`ifdef DOWN_COUNTER_LOAD_EN
   logic       load = 1'b0;
   logic [3:0] load_val = '0;
`endif
   int total = 0;
   int bad = 0;
   int m = 15;
   bit m_tc = 1'b0;
   logic [5:0] exp_v;
   down_counter_4bit dut (
      .clk(clk),
      .rst(rst),
`ifdef DOWN_COUNTER_LOAD_EN
      .load(load),
      .load_val(load_val),
`endif
      .count(count),
      .zero(zero),
      .tc(tc)
   );
   always #5 clk = ~clk;
   task automatic model_reset();
      m = 15;
      m_tc = 1'b0;
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
      m_tc = (m == 0);
      m = (m + 15) % 16;
   endtask
   function automatic logic [5:0] expect_now();
      return {4'(m), m == 0, m_tc};
   endfunction
   task automatic test_reset();
      #1 rst = 1'b0;
      #1;
      model_reset();
      exp_v = expect_now();
      total++;
      if ({count, zero, tc} !== exp_v) begin
         bad++;
         $display("FAIL reset_before_edge: count/zero/tc=%h/%b/%b want %h/%b/%b", count, zero, tc, exp_v[5:2], exp_v[1], exp_v[0]);
      end
      #9;
      total++;
      if ({count, zero, tc} !== exp_v) begin
         bad++;
         $display("FAIL reset_held: count/zero/tc=%h/%b/%b want %h/%b/%b", count, zero, tc, exp_v[5:2], exp_v[1], exp_v[0]);
      end
      rst = 1'b1;
   endtask
   task automatic test_decrement(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         tick();
         exp_v = expect_now();
         total++;
         if ({count, zero, tc} !== exp_v) begin
            bad++;
            $display("FAIL %s[%0d]: count/zero/tc=%h/%b/%b want %h/%b/%b", tag, i, count, zero, tc, exp_v[5:2], exp_v[1], exp_v[0]);
         end
      end
   endtask
   task automatic test_mid_reset();
      total++;
      if (count !== 4'd10) begin
         bad++;
         $display("FAIL mid_reset_start: count=%0d want 10", count);
      end
      rst = 1'b0;
      #1;
      model_reset();
      total++;
      if ({count, tc} !== 5'b11110) begin
         bad++;
         $display("FAIL mid_reset_async: count/tc=%0d/%b want 15/0", count, tc);
      end
      @(posedge clk);
      #1;
      total++;
      if (count !== 4'd15) begin
         bad++;
         $display("FAIL mid_reset_hold: count=%0d want 15", count);
      end
      rst = 1'b1;
      test_decrement(4, "after_reset");
   endtask
   task automatic test_wrap();
      int tc_seen = 0;
      rst = 1'b0;
      #1;
      rst = 1'b1;
      model_reset();
      for (int i = 0; i < 18; i++) begin
         tick();
         exp_v = expect_now();
         tc_seen += tc;
         total++;
         if ({count, zero, tc} !== exp_v) begin
            bad++;
            $display("FAIL wrap[%0d]: count/zero/tc=%h/%b/%b want %h/%b/%b", i, count, zero, tc, exp_v[5:2], exp_v[1], exp_v[0]);
         end
      end
      total++;
      if (tc_seen != 1) begin
         bad++;
         $display("FAIL wrap_tc_count: pulses=%0d want 1", tc_seen);
      end
   endtask
   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 9) == 0) begin
            #($urandom_range(1, 3));
            rst = 1'b0;
            #1;
            model_reset();
            exp_v = expect_now();
            total++;
            if ({count, zero, tc} !== exp_v) begin
               bad++;
               $display("FAIL rand_reset[%0d]: count/zero/tc=%h/%b/%b want %h/%b/%b", i, count, zero, tc, exp_v[5:2], exp_v[1], exp_v[0]);
            end
            #1 rst = 1'b1;
         end
         tick();
         exp_v = expect_now();
         total++;
         if ({count, zero, tc} !== exp_v) begin
            bad++;
            $display("FAIL rand[%0d]: count/zero/tc=%h/%b/%b want %h/%b/%b", i, count, zero, tc, exp_v[5:2], exp_v[1], exp_v[0]);
         end
      end
   endtask
`ifdef DOWN_COUNTER_LOAD_EN
   task automatic test_load();
      while (m != 9) tick();
      load = 1'b1;
      load_val = 4'd3;
      @(posedge clk);
      #1;
      load = 1'b0;
      m = 3;
      m_tc = 1'b0;
      total++;
      if ({count, tc} !== 5'b00110) begin
         bad++;
         $display("FAIL load_value: count/tc=%0d/%b want 3/0", count, tc);
      end
      test_decrement(5, "after_load");
      rst = 1'b0;
      load = 1'b1;
      load_val = 4'd5;
      @(posedge clk);
      #1;
      total++;
      if (count !== 4'd15) begin
         bad++;
         $display("FAIL load_vs_reset: count=%0d want 15", count);
      end
      load = 1'b0;
      rst = 1'b1;
      model_reset();
   endtask
`endif
   initial begin
      test_reset();
      test_decrement(5, "decrement");
      test_mid_reset();
      test_wrap();
`ifdef DOWN_COUNTER_LOAD_EN
      test_load();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
